status_reg: RTL

//  6502 processor status register (P). Captures N/V/Z/C flags from the ALU under a per-flag update mask.

---
 rtl/status_reg.sv | 124 ++++++++++++
 1 files changed

// File: rtl/status_reg.sv
// 6502 processor status register (P): ALU flag capture, flag instructions,
// pull/push images and a registered branch-condition decision.
module status_reg #(
    parameter bit DECIMAL_EN = 1'b1,
    parameter bit RESET_I    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alu_vld,
    input  logic       alu_n,
    input  logic       alu_v,
    input  logic       alu_z,
    input  logic       alu_c,
    input  logic [3:0] upd_mask,
    input  logic [2:0] flag_op,
    input  logic       load_vld,
    input  logic [7:0] load_data,
    input  logic       push_brk,
    input  logic       cond_vld,
    input  logic [2:0] cond,
    output logic [7:0] p_out,
    output logic [7:0] p_push,
    output logic       br_vld,
    output logic       br_taken
);

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_CLC = 3'd1,
        OP_SEC = 3'd2,
        OP_CLI = 3'd3,
        OP_SEI = 3'd4,
        OP_CLD = 3'd5,
        OP_SED = 3'd6,
        OP_CLV = 3'd7
    } flag_op_e;

    logic n_q, v_q, d_q, i_q, z_q, c_q;
    logic n_d, v_d, d_d, i_d, z_d, c_d;
    logic br_vld_q, br_taken_q;
    logic sel_flag;
    flag_op_e op;

    // Bits 5 and 4 of a pulled byte have no storage behind them.
    logic unused_load_bits;
    assign unused_load_bits = ^load_data[5:4];

    assign op = flag_op_e'(flag_op);

    always_comb begin
        n_d = n_q;
        v_d = v_q;
        d_d = d_q;
        i_d = i_q;
        z_d = z_q;
        c_d = c_q;
        if (load_vld) begin
            n_d = load_data[7];
            v_d = load_data[6];
            d_d = DECIMAL_EN & load_data[3];
            i_d = load_data[2];
            z_d = load_data[1];
            c_d = load_data[0];
        end else begin
            if (alu_vld) begin
                if (upd_mask[3]) n_d = alu_n;
                if (upd_mask[2]) v_d = alu_v;
                if (upd_mask[1]) z_d = alu_z;
                if (upd_mask[0]) c_d = alu_c;
            end
            // Applied after the ALU terms so a flag instruction wins on a shared bit.
            case (op)
                OP_CLC:  c_d = 1'b0;
                OP_SEC:  c_d = 1'b1;
                OP_CLI:  i_d = 1'b0;
                OP_SEI:  i_d = 1'b1;
                OP_CLD:  d_d = 1'b0;
                OP_SED:  d_d = DECIMAL_EN;
                OP_CLV:  v_d = 1'b0;
                default: ;
            endcase
        end
    end

    // Branch select uses the current (pre-edge) flags, encoded as opcode bits [7:6].
    always_comb begin
        case (cond[2:1])
            2'b00:   sel_flag = n_q;
            2'b01:   sel_flag = v_q;
            2'b10:   sel_flag = c_q;
            default: sel_flag = z_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q        <= 1'b0;
            v_q        <= 1'b0;
            d_q        <= 1'b0;
            i_q        <= RESET_I;
            z_q        <= 1'b0;
            c_q        <= 1'b0;
            br_vld_q   <= 1'b0;
            br_taken_q <= 1'b0;
        end else begin
            n_q      <= n_d;
            v_q      <= v_d;
            d_q      <= d_d;
            i_q      <= i_d;
            z_q      <= z_d;
            c_q      <= c_d;
            br_vld_q <= cond_vld;
            if (cond_vld) begin
                br_taken_q <= (sel_flag == cond[0]);
            end
        end
    end

    assign p_out    = {n_q, v_q, 1'b1, 1'b1,     d_q, i_q, z_q, c_q};
    assign p_push   = {n_q, v_q, 1'b1, push_brk, d_q, i_q, z_q, c_q};
    assign br_vld   = br_vld_q;
    assign br_taken = br_taken_q;

endmodule
